// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic controller blocks: value width,
// timer state encoding and default prescaler divisor.
package traffic_pkg;

    localparam int unsigned VALUE_W          = 4;
    localparam int unsigned TICK_DIV_DEFAULT = 50;

    typedef enum logic {
        StIdle,
        StCount
    } timer_state_e;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divide-by-TICK_DIV counter with enable and synchronous clear.
// Emits a single-cycle tick on the last count of each period.
module tick_prescaler #(
    parameter int unsigned TICK_DIV = 50
) (
    input  logic clk,
    input  logic sys_reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TICK_DIV - 1);

    logic [CntW-1:0] count_q, count_d;

    assign tick = en && (count_q == CntLast);

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = (count_q == CntLast) ? '0 : count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge sys_reset) begin
        if (!sys_reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/interval_timer.sv
// Loads an interval in seconds on start_timer, counts it down using a
// prescaled tick and pulses expired for one cycle when it reaches zero.
module interval_timer #(
    parameter int unsigned TICK_DIV = traffic_pkg::TICK_DIV_DEFAULT,
    parameter int unsigned VALUE_W  = traffic_pkg::VALUE_W
) (
    input  logic               clk,
    input  logic               sys_reset,
    input  logic [VALUE_W-1:0] value_in,
    input  logic               start_timer,
    input  logic               prg_sync_in,
    output logic               busy,
    output logic [VALUE_W-1:0] remaining,
    output logic               expired
);

    import traffic_pkg::*;

    timer_state_e       state_q, state_d;
    logic [VALUE_W-1:0] remaining_q, remaining_d;
    logic               expired_q, expired_d;
    logic               tick;
    logic               start_ok;
    logic               presc_clr;

    // Reprogramming beats a simultaneous start.
    assign start_ok  = start_timer && !prg_sync_in;
    assign presc_clr = prg_sync_in || start_timer;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk       (clk),
        .sys_reset (sys_reset),
        .en        (state_q == StCount),
        .clr       (presc_clr),
        .tick      (tick)
    );

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        expired_d   = 1'b0;
        if (prg_sync_in) begin
            state_d     = StIdle;
            remaining_d = '0;
        end else if (start_ok) begin
            remaining_d = value_in;
            if (value_in != '0) begin
                state_d = StCount;
            end else begin
                state_d   = StIdle;
                expired_d = 1'b1;
            end
        end else if (tick) begin
            if (remaining_q > VALUE_W'(1)) begin
                remaining_d = remaining_q - 1'b1;
            end else begin
                remaining_d = '0;
                expired_d   = 1'b1;
                state_d     = StIdle;
            end
        end
    end

    always_ff @(posedge clk or negedge sys_reset) begin
        if (!sys_reset) begin
            state_q     <= StIdle;
            remaining_q <= '0;
            expired_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            expired_q   <= expired_d;
        end
    end

    assign busy      = (state_q == StCount);
    assign remaining = remaining_q;
    assign expired   = expired_q;

endmodule

// File: tb/tb_interval_timer.sv
// Directed bench for interval_timer with TICK_DIV=4; expected expiry edges are
// queued at each start and matched against every observed expired pulse.
module tb_interval_timer;

    localparam int unsigned Div = 4;

    logic       clk;
    logic       sys_reset;
    logic [3:0] value_in;
    logic       start_timer;
    logic       prg_sync_in;
    logic       busy;
    logic [3:0] remaining;
    logic       expired;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int exp_q[$];

    interval_timer #(
        .TICK_DIV (Div),
        .VALUE_W  (4)
    ) dut (
        .clk         (clk),
        .sys_reset   (sys_reset),
        .value_in    (value_in),
        .start_timer (start_timer),
        .prg_sync_in (prg_sync_in),
        .busy        (busy),
        .remaining   (remaining),
        .expired     (expired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every expired pulse must match the oldest queued expiry edge.
    always @(negedge clk) begin
        if (sys_reset === 1'b1 && expired === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("spurious_expired_cycle", cyc, 32'hffff_ffff);
            end else begin
                check("expired_cycle", cyc, exp_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int v, input bit push);
        value_in    = 4'(v);
        start_timer = 1'b1;
        step();
        start_timer = 1'b0;
        if (push) exp_q.push_back(cyc + v * Div);
    endtask

    // Called right after the start edge; k counts edges since that start.
    task automatic run_count(input int n, input int cycles);
        for (int k = 0; k <= cycles; k++) begin
            if (k > 0) step();
            check("remaining", remaining, (k >= n * Div) ? 0 : n - k / Div);
            check("busy", busy, (k < n * Div) ? 1 : 0);
            check("expired", expired, (k == n * Div) ? 1 : 0);
        end
    endtask

    task automatic idle(input int cycles);
        for (int k = 0; k < cycles; k++) begin
            step();
            check("idle_busy", busy, 0);
            check("idle_remaining", remaining, 0);
            check("idle_expired", expired, 0);
        end
    endtask

    initial begin
        sys_reset   = 1'b1;
        value_in    = '0;
        start_timer = 1'b0;
        prg_sync_in = 1'b0;

        // Asynchronous reset, observed before any clock edge
        #3 sys_reset = 1'b0;
        #1;
        check("reset_busy", busy, 0);
        check("reset_remaining", remaining, 0);
        check("reset_expired", expired, 0);
        step();
        step();
        sys_reset = 1'b1;
        idle(2);

        // Basic count of 3
        do_start(3, 1'b1);
        run_count(3, 14);

        // Zero value: immediate expiry, never busy
        do_start(0, 1'b1);
        check("zero_busy", busy, 0);
        check("zero_expired", expired, 1);
        idle(3);

        // Restart at E0+6 discards the first count
        do_start(5, 1'b0);
        repeat (5) step();
        do_start(2, 1'b1);
        run_count(2, 9);
        idle(12);

        // Start coinciding with the final tick wins
        do_start(1, 1'b0);
        repeat (3) step();
        do_start(2, 1'b1);
        run_count(2, 9);
        idle(3);

        // Abort mid-count
        do_start(4, 1'b0);
        repeat (4) step();
        prg_sync_in = 1'b1;
        step();
        prg_sync_in = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_remaining", remaining, 0);
        idle(20);

        // Simultaneous start and reprogram, then reprogram held with starts
        value_in    = 4'd7;
        start_timer = 1'b1;
        prg_sync_in = 1'b1;
        step();
        check("both_busy", busy, 0);
        check("both_remaining", remaining, 0);
        for (int k = 0; k < 3; k++) begin
            step();
            check("held_busy", busy, 0);
            check("held_remaining", remaining, 0);
        end
        start_timer = 1'b0;
        prg_sync_in = 1'b0;
        idle(3);

        // Maximum value
        do_start(15, 1'b1);
        run_count(15, 62);

        // Reset mid-count, then a short count
        do_start(9, 1'b0);
        repeat (19) step();
        @(posedge clk);
        #2 sys_reset = 1'b0;
        exp_q.delete();
        #1;
        check("midreset_busy", busy, 0);
        check("midreset_remaining", remaining, 0);
        check("midreset_expired", expired, 0);
        step();
        sys_reset = 1'b1;
        do_start(1, 1'b1);
        run_count(1, 6);
        idle(2);

        check("pending_expiries", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/interval_timer.md
Name: interval_timer

Overview:
- Downstream consumer of the time-parameter store's 4-bit `output_value`.
- On a start pulse from the controller FSM, loads the selected interval and counts it down in seconds, using an internal prescaler.
- Emits a one-cycle `expired` pulse back to the FSM when the count finishes.
- Aborts cleanly when the parameter store is being reprogrammed (`prg_sync_in`).

Parameters:
- TICK_DIV, 50, clk cycles per one-second tick; must be >= 2; the bench uses 4.
- VALUE_W, 4, width of the interval value and remaining count.

Ports:
- clk  input  1  system clock, rising edge.
- sys_reset  input  1  asynchronous, active-low reset; asserted when 0.
- value_in  input  VALUE_W  interval in seconds; driven from the parameter store's output_value.
- start_timer  input  1  single-cycle request to load value_in and begin counting.
- prg_sync_in  input  1  reprogram strobe; aborts any count in progress.
- busy  output  1  high while counting.
- remaining  output  VALUE_W  seconds left in the current count.
- expired  output  1  one-cycle pulse when the count reaches zero.

Behaviour:
- Reset (sys_reset=0, asynchronous): state=IDLE, prescaler=0, remaining=0, busy=0, expired=0. All outputs are registered.
- States: IDLE, COUNT. busy = (state==COUNT).
- Start, sampled at edge E0 with start_timer=1 and prg_sync_in=0:
  - remaining <= value_in; prescaler <= 0.
  - If value_in != 0: state <= COUNT.
  - If value_in == 0: expired=1 for the cycle after E0, state stays IDLE, busy never rises.
- Prescaler:
  - Runs only in COUNT, counting 0..TICK_DIV-1 and wrapping.
  - tick = (prescaler==TICK_DIV-1) && COUNT.
  - The first tick is sampled at edge E0+TICK_DIV.
- Countdown, on each sampled tick:
  - If remaining > 1: remaining decrements by 1.
  - If remaining == 1: remaining <= 0, expired <= 1 for exactly one cycle, state <= IDLE.
  - For value N, expired is high between edges E0+N*TICK_DIV and E0+N*TICK_DIV+1, and busy falls on the same edge.
- Restart: start_timer while busy reloads value_in and zeroes the prescaler. The previous count is discarded; it produces no expired.
- Abort: prg_sync_in=1 sampled in any state → state IDLE, remaining 0, prescaler 0, no expired.
  - prg_sync_in has priority over a simultaneous start_timer; that start is dropped.
  - prg_sync_in held high for multiple cycles keeps the block in IDLE.
- Simultaneous start_timer with the final tick: the start wins. The timer reloads and expired is suppressed.
- Counter arithmetic:
  - Unsigned.
  - Width VALUE_W.
  - remaining never wraps below 0.
  - The maximum value (15) is legal.
- expired never lasts more than 1 cycle; start_timer held high retriggers a reload every cycle, and that is by design.

Decomposition:
- Shared package traffic_pkg holds:
  - VALUE_W constant (4), shared with the parameter store;
  - the timer state enum {IDLE, COUNT};
  - the default TICK_DIV.
- One sub-module, tick_prescaler: TICK_DIV counter with enable and synchronous clear, output tick.
- The countdown and state logic stay in interval_timer.

Test Plan (TICK_DIV=4):
- Reset: assert sys_reset=0 mid-cycle → busy=0, remaining=0, expired=0 immediately, without waiting for a clock edge.
- Basic count: value_in=3, start at E0 → remaining reads 3/2/1/0 after E0/E0+4/E0+8/E0+12; expired high only in the cycle after E0+12; busy high from E0 to E0+12.
- Zero value: value_in=0, start → expired high the single cycle after E0; busy stays 0.
- Restart: value_in=5, start at E0; at E0+6 start with value_in=2 → no expired before E0+14; expired after E0+14, one cycle.
- Abort: value_in=4, start, prg_sync_in=1 at E0+5 → busy=0, remaining=0, no expired ever. Repeat with start_timer and prg_sync_in both high on the same edge → remains IDLE.
- Max and reset-mid-count: value_in=15 → expired after E0+60. Separately, assert reset at E0+20, release, then start with value_in=1 → expired after 4 cycles.
